// File: rtl/mt_pkg.sv
// Shared types and helpers for the barrel mt_cpu thread scheduler.
package mt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2,
    HALTED   = 2'd3
  } thread_state_t;

  function automatic int tid_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Caller truncates to its PC width, giving the modulo wrap.
  function automatic logic [63:0] boot_pc(
    input logic [63:0] base,
    input logic [63:0] stride,
    input int          t
  );
    return base + stride * 64'(t);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set mask bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] tid
);

  // Scan from the far end so the closest candidate wins last.
  always_comb begin
    found = 1'b0;
    tid   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        tid   = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/barrel_thread_sched.sv
// Barrel thread scheduler: round-robin fetch selection, one
// instruction in flight per thread, per-thread PC ownership.
module barrel_thread_sched
  import mt_pkg::*;
#(
  parameter int                   NUM_THREADS      = 8,
  parameter int                   ADDRESS_WIDTH    = 32,
  parameter int                   TID_WIDTH        = tid_w(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = '0,
  parameter logic [NUM_THREADS-1:0]   BOOT_MASK        = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  output logic                     issue_valid,
  output logic [TID_WIDTH-1:0]     issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  input  logic                     retire_valid,
  input  logic [TID_WIDTH-1:0]     retire_tid,
  input  logic [ADDRESS_WIDTH-1:0] retire_next_pc,
  input  logic                     retire_halt,
  input  logic                     start_valid,
  input  logic [TID_WIDTH-1:0]     start_tid,
  input  logic [ADDRESS_WIDTH-1:0] start_pc,
  output logic [NUM_THREADS-1:0]   thread_active,
  output logic                     all_halted,
  output logic                     protocol_err
);

  thread_state_t              st [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0]   pc [NUM_THREADS];
  logic [TID_WIDTH-1:0]       rr_ptr;
  logic [NUM_THREADS-1:0]     ready;
  logic                       found;
  logic [TID_WIDTH-1:0]       pick;
  logic                       rt_in;
  logic                       st_in;
  logic                       ret_ok;
  logic                       start_ok;

  always_comb begin
    ready         = '0;
    thread_active = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      ready[t]         = (st[t] == READY);
      thread_active[t] = (st[t] == READY) || (st[t] == INFLIGHT);
    end
  end

  assign all_halted = ~|thread_active && !issue_valid;

  rr_pick #(
    .N(NUM_THREADS),
    .W(TID_WIDTH)
  ) u_pick (
    .mask (ready),
    .ptr  (rr_ptr),
    .found(found),
    .tid  (pick)
  );

  assign rt_in = 32'(retire_tid) < 32'(NUM_THREADS);
  assign st_in = 32'(start_tid) < 32'(NUM_THREADS);

  // A legal retire needs INFLIGHT and a legal start needs IDLE/HALTED,
  // so neither can collide with the picked (READY) thread or each other.
  always_comb begin
    ret_ok   = 1'b0;
    start_ok = 1'b0;
    if (retire_valid && rt_in)
      ret_ok = (st[retire_tid] == INFLIGHT);
    if (start_valid && st_in)
      start_ok = (st[start_tid] == IDLE) || (st[start_tid] == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_tid    <= '0;
      issue_pc     <= '0;
      protocol_err <= 1'b0;
      rr_ptr       <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= ADDRESS_WIDTH'(boot_pc(64'(RESET_PC),
                                        64'(THREAD_PC_STRIDE), t));
        st[t] <= BOOT_MASK[t] ? READY : IDLE;
      end
    end else begin
      if (!stall) begin
        issue_valid <= found;
        if (found) begin
          issue_tid   <= pick;
          issue_pc    <= pc[pick];
          st[pick]    <= INFLIGHT;
          rr_ptr      <= (32'(pick) == 32'(NUM_THREADS - 1)) ?
                         '0 : pick + 1'b1;
        end
      end
      if (ret_ok) begin
        pc[retire_tid] <= retire_next_pc;
        st[retire_tid] <= retire_halt ? HALTED : READY;
      end
      if (start_ok) begin
        pc[start_tid] <= start_pc;
        st[start_tid] <= READY;
      end
      if ((retire_valid && !ret_ok) || (start_valid && !start_ok))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Directed self-checking bench for barrel_thread_sched.
module tb_barrel_thread_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        issue_valid;
  logic [2:0]  issue_tid;
  logic [31:0] issue_pc;
  logic        retire_valid;
  logic [2:0]  retire_tid;
  logic [31:0] retire_next_pc;
  logic        retire_halt;
  logic        start_valid;
  logic [2:0]  start_tid;
  logic [31:0] start_pc;
  logic [7:0]  thread_active;
  logic        all_halted;
  logic        protocol_err;

  int vectors = 0;
  int errors  = 0;

  barrel_thread_sched #(
    .THREAD_PC_STRIDE(32'h100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .issue_valid   (issue_valid),
    .issue_tid     (issue_tid),
    .issue_pc      (issue_pc),
    .retire_valid  (retire_valid),
    .retire_tid    (retire_tid),
    .retire_next_pc(retire_next_pc),
    .retire_halt   (retire_halt),
    .start_valid   (start_valid),
    .start_tid     (start_tid),
    .start_pc      (start_pc),
    .thread_active (thread_active),
    .all_halted    (all_halted),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    retire_valid   = 1'b0;
    retire_tid     = '0;
    retire_next_pc = '0;
    retire_halt    = 1'b0;
    start_valid    = 1'b0;
    start_tid      = '0;
    start_pc       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    vectors++;
    if ({issue_valid, issue_tid, issue_pc} !== 36'h0) begin
      errors++;
      $display("FAIL reset_issue got v=%b t=%0d pc=%h want 0",
               issue_valid, issue_tid, issue_pc);
    end
    vectors++;
    if (protocol_err !== 1'b0 || thread_active !== 8'hff ||
        all_halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got err=%b act=%h ah=%b want 0 ff 0",
               protocol_err, thread_active, all_halted);
    end
    rst = 1'b0;
  endtask

  task automatic test_boot_issue();
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (issue_valid !== 1'b1 || issue_tid !== 3'(i) ||
          issue_pc !== 32'(i * 32'h100) || all_halted !== 1'b0) begin
        errors++;
        $display("FAIL boot_issue%0d got v=%b t=%0d pc=%h ah=%b want 1 %0d %h 0",
                 i, issue_valid, issue_tid, issue_pc, all_halted,
                 i, i * 32'h100);
      end
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0 || all_halted !== 1'b0 ||
        thread_active !== 8'hff) begin
      errors++;
      $display("FAIL boot_drain got v=%b ah=%b act=%h want 0 0 ff",
               issue_valid, all_halted, thread_active);
    end
  endtask

  task automatic test_single_retire();
    retire_valid   = 1'b1;
    retire_tid     = 3'd0;
    retire_next_pc = 32'h4;
    tick();
    retire_valid = 1'b0;
    vectors++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire_gap got v=%b want 0", issue_valid);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd0 || issue_pc !== 32'h4) begin
      errors++;
      $display("FAIL retire_reissue got v=%b t=%0d pc=%h want 1 0 4",
               issue_valid, issue_tid, issue_pc);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire_pulse got v=%b want 0", issue_valid);
    end
  endtask

  task automatic test_stall();
    retire_valid   = 1'b1;
    retire_tid     = 3'd2;
    retire_next_pc = 32'h204;
    tick();
    retire_tid     = 3'd3;
    retire_next_pc = 32'h304;
    tick();
    retire_valid = 1'b0;
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd2 ||
        issue_pc !== 32'h204) begin
      errors++;
      $display("FAIL stall_pre got v=%b t=%0d pc=%h want 1 2 204",
               issue_valid, issue_tid, issue_pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (issue_valid !== 1'b1 || issue_tid !== 3'd2 ||
          issue_pc !== 32'h204) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b t=%0d pc=%h want 1 2 204",
                 i, issue_valid, issue_tid, issue_pc);
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd3 ||
        issue_pc !== 32'h304) begin
      errors++;
      $display("FAIL stall_release got v=%b t=%0d pc=%h want 1 3 304",
               issue_valid, issue_tid, issue_pc);
    end
    tick();
  endtask

  task automatic test_halt_start();
    retire_valid = 1'b1;
    retire_halt  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      retire_tid = 3'(i);
      tick();
    end
    retire_valid = 1'b0;
    retire_halt  = 1'b0;
    vectors++;
    if (all_halted !== 1'b1 || thread_active !== 8'h00 ||
        issue_valid !== 1'b0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL halt_all got ah=%b act=%h v=%b err=%b want 1 00 0 0",
               all_halted, thread_active, issue_valid, protocol_err);
    end
    start_valid = 1'b1;
    start_tid   = 3'd5;
    start_pc    = 32'h40;
    tick();
    start_valid = 1'b0;
    vectors++;
    if (issue_valid !== 1'b0 || all_halted !== 1'b0 ||
        thread_active !== 8'h20) begin
      errors++;
      $display("FAIL start_ready got v=%b ah=%b act=%h want 0 0 20",
               issue_valid, all_halted, thread_active);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd5 || issue_pc !== 32'h40) begin
      errors++;
      $display("FAIL start_issue got v=%b t=%0d pc=%h want 1 5 40",
               issue_valid, issue_tid, issue_pc);
    end
  endtask

  task automatic test_protocol();
    start_valid = 1'b1;
    start_tid   = 3'd1;
    start_pc    = 32'h10;
    tick();
    start_valid    = 1'b0;
    retire_valid   = 1'b1;
    retire_tid     = 3'd1;
    retire_next_pc = 32'h99;
    tick();
    retire_valid = 1'b0;
    vectors++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_retire_ready got err=%b want 1", protocol_err);
    end
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd1 || issue_pc !== 32'h10) begin
      errors++;
      $display("FAIL err_old_pc got v=%b t=%0d pc=%h want 1 1 10",
               issue_valid, issue_tid, issue_pc);
    end
    start_valid = 1'b1;
    start_tid   = 3'd1;
    start_pc    = 32'h77;
    tick();
    start_valid = 1'b0;
    tick();
    vectors++;
    if (issue_valid !== 1'b0 || thread_active !== 8'h22 ||
        protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_start_inflight got v=%b act=%h err=%b want 0 22 1",
               issue_valid, thread_active, protocol_err);
    end
    retire_valid   = 1'b1;
    retire_tid     = 3'd5;
    retire_next_pc = 32'h50;
    start_valid    = 1'b1;
    start_tid      = 3'd5;
    start_pc       = 32'h60;
    tick();
    retire_valid = 1'b0;
    start_valid  = 1'b0;
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd5 || issue_pc !== 32'h50) begin
      errors++;
      $display("FAIL retire_start_same got v=%b t=%0d pc=%h want 1 5 50",
               issue_valid, issue_tid, issue_pc);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({issue_valid, issue_tid, issue_pc} !== 36'h0 ||
        protocol_err !== 1'b0 || thread_active !== 8'hff) begin
      errors++;
      $display("FAIL async_reset got v=%b t=%0d pc=%h err=%b act=%h want 0 0 0 0 ff",
               issue_valid, issue_tid, issue_pc, protocol_err, thread_active);
    end
    tick();
    rst            = 1'b0;
    retire_valid   = 1'b1;
    retire_tid     = 3'd5;
    retire_next_pc = 32'h555;
    tick();
    retire_valid = 1'b0;
    vectors++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL stale_retire got err=%b want 1", protocol_err);
    end
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd0 || issue_pc !== 32'h0) begin
      errors++;
      $display("FAIL restart_tid0 got v=%b t=%0d pc=%h want 1 0 0",
               issue_valid, issue_tid, issue_pc);
    end
    for (int i = 1; i < 6; i++) tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd5 ||
        issue_pc !== 32'h500) begin
      errors++;
      $display("FAIL boot_pc_restored got v=%b t=%0d pc=%h want 1 5 500",
               issue_valid, issue_tid, issue_pc);
    end
  endtask

  initial begin
    test_reset();
    test_boot_issue();
    test_single_retire();
    test_stall();
    test_halt_start();
    test_protocol();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
